// File: rtl/mult_scheduler.sv
// mult_scheduler: round-robin front end that shares one shift-add multiplier
// datapath (adder + AQ register, external) among N_REQ requesters.
//
// Ports
//   clock, reset      : system clock, synchronous active-high reset
//   req               : per-requester request level, held until its done pulse
//   req_m, req_q      : packed multiplicands / multipliers, requester i at [i*WIDTH +: WIDTH]
//   grant             : one-hot owner of the datapath, zero when idle
//   done              : one-hot, one-cycle completion pulse
//   result            : product of the last completed operation
//   busy              : high whenever the sequencer is not idle
//   mul_M, mul_Qin    : latched operands driven to the datapath
//   mul_load/add/shift: datapath control strobes (one-hot or zero)
//   mul_AQ            : datapath {A,Q} register; bit 0 is Q0
module mult_scheduler #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned WIDTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_m,
    input  logic [N_REQ*WIDTH-1:0]   req_q,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic [2*WIDTH-1:0]       result,
    output logic                     busy,
    output logic [WIDTH-1:0]         mul_M,
    output logic [WIDTH-1:0]         mul_Qin,
    output logic                     mul_load,
    output logic                     mul_add,
    output logic                     mul_shift,
    input  logic [2*WIDTH-1:0]       mul_AQ
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW    = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e             state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [PW-1:0]      result_q, result_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   mul_m_q, mul_m_d;
    logic [WIDTH-1:0]   mul_qin_q, mul_qin_d;
    logic               mul_load_q, mul_load_d;
    logic               mul_add_q, mul_add_d;
    logic               mul_shift_q, mul_shift_d;

    logic               win_found_c;
    logic [IDX_W-1:0]   win_idx_c;
    int unsigned        arb_cand;

    // Round-robin pick: first requester searching upward from ptr+1, wrapping.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        arb_cand    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            arb_cand = 32'(ptr_q) + k;
            if (arb_cand >= N_REQ) begin
                arb_cand = arb_cand - N_REQ;
            end
            if (!win_found_c && req[IDX_W'(arb_cand)]) begin
                win_found_c = 1'b1;
                win_idx_c   = IDX_W'(arb_cand);
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath-side register updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        result_d  = result_q;
        mul_m_d   = mul_m_q;
        mul_qin_d = mul_qin_q;

        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (win_found_c) begin
                    state_d   = S_LOAD;
                    gidx_d    = win_idx_c;
                    grant_d   = N_REQ'(1) << win_idx_c;
                    mul_m_d   = req_m[win_idx_c*WIDTH +: WIDTH];
                    mul_qin_d = req_q[win_idx_c*WIDTH +: WIDTH];
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_TEST;
            end
            S_TEST: begin
                // Q0 of the datapath decides whether this bit needs an add.
                state_d = mul_AQ[0] ? S_ADD : S_SHIFT;
            end
            S_ADD: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? S_DONE : S_TEST;
            end
            S_DONE: begin
                result_d = mul_AQ;
                ptr_d    = gidx_q;
                grant_d  = '0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Outputs decoded from the upcoming state so they are registered yet
    // aligned with the state they belong to.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        mul_load_d  = (state_d == S_LOAD);
        mul_add_d   = (state_d == S_ADD);
        mul_shift_d = (state_d == S_SHIFT);
        done_d      = (state_d == S_DONE) ? grant_q : '0;
    end

    // Data and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            ptr_q       <= IDX_W'(N_REQ - 1);
            gidx_q      <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            mul_m_q     <= '0;
            mul_qin_q   <= '0;
            mul_load_q  <= 1'b0;
            mul_add_q   <= 1'b0;
            mul_shift_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            mul_m_q     <= mul_m_d;
            mul_qin_q   <= mul_qin_d;
            mul_load_q  <= mul_load_d;
            mul_add_q   <= mul_add_d;
            mul_shift_q <= mul_shift_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign mul_M     = mul_m_q;
    assign mul_Qin   = mul_qin_q;
    assign mul_load  = mul_load_q;
    assign mul_add   = mul_add_q;
    assign mul_shift = mul_shift_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Bench for mult_scheduler: two instances (N_REQ=2 and N_REQ=4), each wired
// to a behavioural shift-add datapath {C,A,Q}.
module tb_mult_scheduler;

    logic clock;
    logic reset;

    // N_REQ = 2 instance
    logic [1:0] req2, grant2, done2;
    logic [7:0] req_m2, req_q2, result2, aq2;
    logic [3:0] mm2, mq2;
    logic       busy2, ld2, ad2, sh2;

    // N_REQ = 4 instance
    logic [3:0]  req4, grant4, done4;
    logic [15:0] req_m4, req_q4;
    logic [7:0]  result4, aq4;
    logic [3:0]  mm4, mq4;
    logic        busy4, ld4, ad4, sh4;

    int n_pass = 0;
    int n_total = 0;

    mult_scheduler #(.N_REQ(2), .WIDTH(4)) u2 (
        .clock(clock), .reset(reset), .req(req2), .req_m(req_m2), .req_q(req_q2),
        .grant(grant2), .done(done2), .result(result2), .busy(busy2),
        .mul_M(mm2), .mul_Qin(mq2), .mul_load(ld2), .mul_add(ad2),
        .mul_shift(sh2), .mul_AQ(aq2)
    );

    mult_scheduler #(.N_REQ(4), .WIDTH(4)) u4 (
        .clock(clock), .reset(reset), .req(req4), .req_m(req_m4), .req_q(req_q4),
        .grant(grant4), .done(done4), .result(result4), .busy(busy4),
        .mul_M(mm4), .mul_Qin(mq4), .mul_load(ld4), .mul_add(ad4),
        .mul_shift(sh4), .mul_AQ(aq4)
    );

    // Shift-add datapath models: load clears A and C, add does {C,A}=A+M,
    // shift moves {C,A,Q} right by one.
    logic       c2, c4;
    logic [3:0] a2, q2, a4, q4;
    assign aq2 = {a2, q2};
    assign aq4 = {a4, q4};

    always @(posedge clock) begin
        if (reset) begin
            {c2, a2, q2} <= '0;
        end else if (ld2) begin
            c2 <= 1'b0; a2 <= 4'd0; q2 <= mq2;
        end else if (ad2) begin
            {c2, a2} <= {1'b0, a2} + {1'b0, mm2};
        end else if (sh2) begin
            {c2, a2, q2} <= {1'b0, c2, a2, q2[3:1]};
        end
    end

    always @(posedge clock) begin
        if (reset) begin
            {c4, a4, q4} <= '0;
        end else if (ld4) begin
            c4 <= 1'b0; a4 <= 4'd0; q4 <= mq4;
        end else if (ad4) begin
            {c4, a4} <= {1'b0, a4} + {1'b0, mm4};
        end else if (sh4) begin
            {c4, a4, q4} <= {1'b0, c4, a4, q4[3:1]};
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         who;
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] res;
        int         cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %s expected %s", name, act, exp);
    endtask

    // Expected strobe trace: L, then per bit LSB first T[A]S, then D.
    function automatic string exp_seq(input logic [3:0] q);
        string s;
        s = "L";
        for (int i = 0; i < 4; i++) begin
            s = {s, "T"};
            if (q[i]) s = {s, "A"};
            s = {s, "S"};
        end
        s = {s, "D"};
        return s;
    endfunction

    function automatic bit cond(input int which);
        case (which)
            0: return done2 != 2'b00;
            1: return ad2;
            default: return done4 != 4'b0000;
        endcase
    endfunction

    // Bounded wait; an expired bound counts as a failed comparison.
    task automatic wait_cond(input int which, input string name);
        for (int c = 0; c < 60; c++) begin
            if (cond(which)) break;
            tick();
        end
        chk(name, 32'(cond(which)), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req2 = '0;
        req4 = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_op(input int who, input logic [3:0] m, input logic [3:0] q,
                          input logic [7:0] res, input int cyc);
        int    n;
        string s;
        bit    seen;
        bit    g_ok;
        logic [1:0] exp_g;
        exp_g = 2'(1 << who);
        req_m2[who*4 +: 4] = m;
        req_q2[who*4 +: 4] = q;
        req2 = exp_g;
        n = 0; s = ""; seen = 1'b0; g_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (busy2) begin
                if (n == 0) chk("op_operands", {24'd0, mm2, mq2}, {24'd0, m, q});
                if (grant2 !== exp_g) g_ok = 1'b0;
                n++;
                if (ld2)               s = {s, "L"};
                else if (ad2)          s = {s, "A"};
                else if (sh2)          s = {s, "S"};
                else if (done2 != 0)   s = {s, "D"};
                else                   s = {s, "T"};
            end
            if (done2 != 2'b00) begin
                seen = 1'b1;
                chk("op_done_onehot", 32'(done2), 32'(exp_g));
                req2 = '0;
                break;
            end
        end
        chk("op_done_seen", 32'(seen), 32'd1);
        chk("op_grant_stable", 32'(g_ok), 32'd1);
        chk("op_busy_cycles", n, cyc);
        chk_str("op_strobes", s, exp_seq(q));
        tick();
        chk("op_result", 32'(result2), 32'(res));
        chk("op_idle_after", {27'd0, busy2, grant2, done2}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req2 = '0; req_m2 = '0; req_q2 = '0;
        req4 = '0; req_m4 = '0; req_q4 = '0;

        vecs[0] = '{who: 0, m: 4'h5, q: 4'h7, res: 8'h23, cyc: 13};
        vecs[1] = '{who: 0, m: 4'hF, q: 4'hF, res: 8'hE1, cyc: 14};
        vecs[2] = '{who: 0, m: 4'hA, q: 4'h0, res: 8'h00, cyc: 10};
        vecs[3] = '{who: 1, m: 4'h3, q: 4'h4, res: 8'h0C, cyc: 11};
        vecs[4] = '{who: 1, m: 4'hF, q: 4'h1, res: 8'h0F, cyc: 11};
        vecs[5] = '{who: 0, m: 4'h1, q: 4'h8, res: 8'h08, cyc: 11};

        do_reset();
        chk("reset_state", {grant2, done2, busy2, ld2, ad2, sh2, result2, mm2, mq2}, 32'd0);
        chk("reset_state_n4", {grant4, done4, busy4, ld4, ad4, sh4, result4}, 32'd0);

        // Single-requester table
        foreach (vecs[i]) begin
            run_op(vecs[i].who, vecs[i].m, vecs[i].q, vecs[i].res, vecs[i].cyc);
        end

        // Both requesters held: alternate r0, r1 with one idle cycle between
        do_reset();
        req_m2 = {4'd2, 4'd3};
        req_q2 = {4'd5, 4'd4};
        req2 = 2'b11;
        for (int op = 0; op < 4; op++) begin
            int who;
            who = op % 2;
            wait_cond(0, "rr_wait_done");
            chk("rr_done", 32'(done2), 32'(1 << who));
            tick();
            if (op == 3) req2 = '0;
            chk("rr_result", 32'(result2), (who == 0) ? 32'h0C : 32'h0A);
            chk("rr_idle_gap", {29'd0, busy2, grant2}, 32'd0);
            if (op < 3) begin
                tick();
                chk("rr_next_grant", {29'd0, busy2, grant2}, {29'd0, 1'b1, 2'(1 << (1 - who))});
            end
        end
        tick();
        chk("rr_stays_idle", 32'(busy2), 32'd0);

        // r0 completes last so its pointer would favour r1, then reset r1 mid-ADD
        run_op(0, 4'h2, 4'h3, 8'h06, 12);
        req_m2[7:4] = 4'd3;
        req_q2[7:4] = 4'd5;
        req2 = 2'b10;
        wait_cond(1, "rst_wait_add");
        reset = 1'b1;
        req_m2[3:0] = 4'd7;
        req_q2[3:0] = 4'd2;
        req2 = 2'b11;
        tick();
        reset = 1'b0;
        chk("rst_outputs_zero", {grant2, done2, busy2, ld2, ad2, sh2, result2, mm2, mq2}, 32'd0);
        tick();
        chk("rst_first_grant_r0", 32'(grant2), 32'd1);
        wait_cond(0, "rst_wait_done");
        chk("rst_done_r0", 32'(done2), 32'd1);
        req2 = '0;
        tick();
        chk("rst_result", 32'(result2), 32'h0E);

        // r1 drops req and changes operands mid-operation
        req_m2[7:4] = 4'd6;
        req_q2[7:4] = 4'd3;
        req2 = 2'b10;
        tick();
        chk("drop_grant", {29'd0, ld2, grant2}, {29'd0, 1'b1, 2'b10});
        tick();
        tick();
        req2 = '0;
        req_m2[7:4] = 4'hF;
        req_q2[7:4] = 4'hF;
        wait_cond(0, "drop_wait_done");
        chk("drop_done_r1", 32'(done2), 32'd2);
        tick();
        chk("drop_result", 32'(result2), 32'h12);

        // N_REQ=4: requests on 1 and 3 from reset pointer 3, r0 joins later
        do_reset();
        req_m4 = {4'd3, 4'd0, 4'd2, 4'd4};
        req_q4 = {4'd3, 4'd0, 4'd3, 4'd2};
        req4 = 4'b1010;
        tick();
        chk("n4_first_grant", 32'(grant4), 32'b0010);
        req4 = 4'b1011;
        for (int op = 0; op < 3; op++) begin
            logic [3:0] exp_g [3];
            logic [7:0] exp_r [3];
            exp_g = '{4'b0010, 4'b1000, 4'b0001};
            exp_r = '{8'h06, 8'h09, 8'h08};
            wait_cond(2, "n4_wait_done");
            chk("n4_done", 32'(done4), 32'(exp_g[op]));
            if (op == 2) req4 = '0;
            tick();
            chk("n4_result", 32'(result4), 32'(exp_r[op]));
            chk("n4_idle_gap", 32'(busy4), 32'd0);
            if (op < 2) begin
                tick();
                chk("n4_next_grant", 32'(grant4), 32'(exp_g[op + 1]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_scheduler.md
Name: mult_scheduler

Overview:
- Shares one WIDTH x WIDTH shift-add multiplier datapath (adder + AQ register) among N_REQ requesters.
- Arbitrates round-robin, loads the winner's operands and sequences load/add/shift from the datapath's Q0 feedback.
- Returns the 2*WIDTH product to the winner with a one-cycle done pulse.
- Takes over the role of the single-start sequencer when several clients need the multiplier.

Parameters:
N_REQ, 2, number of requesters (2..8)
WIDTH, 4, operand width; product width is 2*WIDTH

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
req  input  N_REQ  per-requester request level; held until that requester's done
req_m  input  N_REQ*WIDTH  multiplicands, requester i at [i*WIDTH +: WIDTH]
req_q  input  N_REQ*WIDTH  multipliers, same packing
grant  output  N_REQ  one-hot owner of the datapath; 0 when idle
done  output  N_REQ  one-hot, one-cycle completion pulse
result  output  2*WIDTH  product of the last completed operation
busy  output  1  high whenever state is not IDLE
mul_M  output  WIDTH  multiplicand to datapath (latched)
mul_Qin  output  WIDTH  multiplier to datapath (latched)
mul_load  output  1  datapath: A<=0, Q<=mul_Qin
mul_add  output  1  datapath: {C,A}<=A+mul_M
mul_shift  output  1  datapath: {C,A,Q} >> 1
mul_AQ  input  2*WIDTH  datapath register contents; bit 0 is Q0

Behaviour:
- Reset (sync, highest priority, any state): state=IDLE; grant, done, busy, mul_load, mul_add, mul_shift=0; result=0; mul_M, mul_Qin=0; bit counter=0; last-grant pointer=N_REQ-1, so requester 0 wins first.
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE. Control strobes are decoded from state and are one-hot or zero.
- IDLE: if any req bit is high, pick the first requester searching upward from pointer+1 with wrap-around.
  - Latch its index into grant and its operands into mul_M/mul_Qin.
  - Go to LOAD.
  - If no request, stay in IDLE.
- LOAD: mul_load=1 for one cycle; counter=0; go to TEST.
- TEST: no strobe. If mul_AQ[0]=1, go to ADD, else go to SHIFT.
- ADD: mul_add=1 for one cycle; go to SHIFT.
- SHIFT: mul_shift=1 for one cycle; counter+1.
  - If counter was WIDTH-1, go to DONE.
  - Otherwise go to TEST.
- DONE:
  - result<=mul_AQ.
  - done[grant index]=1 for this cycle only.
  - pointer<=grant index.
  - Go to IDLE, where grant is cleared.
- grant, mul_M and mul_Qin are stable from LOAD through DONE. Operands are sampled only in IDLE; later changes to req_m/req_q are ignored.
- Busy length per operation = 1 (LOAD) + sum over bits of (2 + q_bit) + 1 (DONE).
  - 0111 gives 13 cycles.
  - 0000 gives 10 cycles.
  - 1111 gives 14 cycles.
- result holds its value until the next DONE; it is not cleared when the next operation starts.
- A requester dropping req mid-operation does not abort it. The operation completes, done still pulses and result is updated.
- After done, a requester still holding req in the following IDLE cycle is treated as a new request, subject to round-robin.
- Back-to-back: IDLE always lasts at least one cycle between operations.
- Simultaneous requests: exactly one is granted. The others wait. With continuous requests, no requester waits more than N_REQ-1 operations.
- Product arithmetic is unsigned; the maximum (2^WIDTH-1)^2 fits in 2*WIDTH bits. The carry is held by the datapath.

Test Plan:
- Single requester 0, m=0101, q=0111 -> grant=01, busy high 13 cycles, strobe sequence L,T,A,S,T,A,S,T,A,S,T,S; done[0] pulse; result=8'h23.
- m=1111, q=1111 -> 14 busy cycles, result=8'hE1. Then m=1010, q=0000 -> no mul_add ever, 10 cycles, result=8'h00.
- Both requesters held high (r0: 3x4, r1: 2x5) -> order r0,r1,r0,r1; results 8'h0C, 8'h0A alternating; one idle cycle between operations; done never two-hot.
- Reset asserted during an ADD state -> next cycle all outputs zero, state IDLE; first request after reset goes to requester 0 even if r1 was mid-operation.
- Requester 1 drops req and changes req_m during an operation -> operation completes with the latched operands, done[1] pulses, correct result.
- N_REQ=4: requests on 1 and 3 with pointer=3 -> requester 1 granted first, then 3; requester 0 granted within 3 operations when it joins.
